// File: rtl/eyeriss_buf_pkg.sv
// rtl/eyeriss_buf_pkg.sv - shared FSM state type and default sizes for the buffer reader
package eyeriss_buf_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/buffer_addr_gen.sv
// rtl/buffer_addr_gen.sv - address register, stride adder and issued-beat counter
module buffer_addr_gen #(
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last_issue
);

  localparam logic [LEN_WIDTH-1:0] INC     = 1;
  localparam logic [LEN_WIDTH:0]   INC_EXT = 1;

  logic [ADDR_WIDTH-1:0] stride_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      stride_q <= '0;
      len_q    <= '0;
      issued   <= '0;
    end else if (load) begin
      addr     <= base;
      stride_q <= stride;
      len_q    <= length;
      issued   <= '0;
    end else if (advance) begin
      addr   <= addr + stride_q;
      issued <= issued + INC;
    end
  end

  // High while the beat about to be issued is the final one of the command.
  assign last_issue = (({1'b0, issued} + INC_EXT) == {1'b0, len_q});

endmodule

// File: rtl/buffer_reader.sv
// rtl/buffer_reader.sv - strided Buffer reader with registered valid/ready output
// Optional stall counter output enabled by BUFFER_READER_STALL_CNT_EN.
module buffer_reader
  import eyeriss_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int PAR_READ   = 1,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [LEN_WIDTH-1:0]           length,
  input  logic [ADDR_WIDTH-1:0]          stride,
  output logic [ADDR_WIDTH-1:0]          buf_read_addr,
  input  logic [PAR_READ*DATA_WIDTH-1:0] buf_read_data,
  output logic [PAR_READ*DATA_WIDTH-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done
`ifdef BUFFER_READER_STALL_CNT_EN
  ,
  output logic [15:0]                    stall_cycles
`endif
);

  rd_state_t state, state_nxt;
  logic      primed;
  logic      cmd_load;
  logic      beat_load;
  logic      done_set;
  logic      last_issue;

  buffer_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (cmd_load),
    .advance    (beat_load),
    .base       (base_addr),
    .stride     (stride),
    .length     (length),
    .addr       (buf_read_addr),
    .last_issue (last_issue)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_load  = 1'b0;
    beat_load = 1'b0;
    done_set  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_set = 1'b1;
          end else begin
            cmd_load  = 1'b1;
            state_nxt = READ;
          end
        end
      end
      READ: begin
        if (primed && (!out_valid || out_ready)) begin
          beat_load = 1'b1;
          if (last_issue) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          done_set  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // First READ cycle only lets the freshly loaded address settle on the Buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      primed    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      primed <= (state == READ);
      done   <= done_set;
      if (beat_load) begin
        out_data  <= buf_read_data;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef BUFFER_READER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (state == IDLE && start) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: doc/buffer_reader.md
BUFFER_READER -- requirements
Module: buffer_reader

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 16: bits per buffer word.
- REQ-002 SHALL have parameter DEPTH, default 16: words in the attached Buffer.
- REQ-003 SHALL have parameter PAR_READ, default 1: words returned per beat.
- REQ-004 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH): buffer address width.
- REQ-005 SHALL have parameter LEN_WIDTH, default 8: width of the beat count.
- REQ-006 SHALL have port clk, input, 1: the single clock, all logic on its rising edge.
- REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
- REQ-008 SHALL have port start, input, 1: command strobe, accepted only in IDLE.
- REQ-009 SHALL have port base_addr, input, ADDR_WIDTH: first read address.
- REQ-010 SHALL have port length, input, LEN_WIDTH: beats to emit.
- REQ-011 SHALL have port stride, input, ADDR_WIDTH: address increment per beat.
- REQ-012 SHALL have port buf_read_addr, output, ADDR_WIDTH: address to the Buffer read port.
- REQ-013 SHALL have port buf_read_data, input, PAR_READ*DATA_WIDTH: combinational read data from the Buffer.
- REQ-014 SHALL have port out_data, output, PAR_READ*DATA_WIDTH: registered beat.
- REQ-015 SHALL have port out_valid, input out_ready, 1 each: downstream handshake.
- REQ-016 SHALL have ports busy and done, output, 1 each: command active, and a one-cycle completion pulse.

Function
- REQ-017 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE.
- REQ-018 IDLE with start=1 SHALL capture base_addr, stride and length, and enter READ.
- REQ-019 IDLE with start=1 and length=0 SHALL stay in IDLE, pulse done next cycle, and never assert out_valid.
- REQ-020 In READ, a "load" SHALL occur when (!out_valid || out_ready): out_data <= buf_read_data, out_valid <= 1, addr <= addr + stride, issued <= issued + 1.
- REQ-021 Address arithmetic SHALL be modulo 2^ADDR_WIDTH (silent wrap-around).
- REQ-022 buf_read_addr SHALL be driven directly from the address register.
- REQ-023 When issued reaches length, the FSM SHALL enter DRAIN.
- REQ-024 In DRAIN, on out_valid && out_ready, out_valid SHALL clear, done SHALL pulse, and the FSM SHALL return to IDLE.
- REQ-025 Latency: with start accepted at edge 0, out_valid SHALL first be high after edge 2.
- REQ-026 With out_ready held high, throughput SHALL be one beat per cycle with no bubbles.
- REQ-027 out_data and out_valid SHALL hold stable while out_valid && !out_ready.
- REQ-028 start SHALL be ignored while busy; busy = (state != IDLE).
- REQ-029 done SHALL be high exactly one cycle per accepted command and SHALL coincide with the cycle in which busy returns to 0.

Reset
- REQ-030 rst SHALL force, at the next edge: state=IDLE, out_valid=0, out_data=0, buf_read_addr=0, busy=0, done=0, and all counters=0.
- REQ-031 rst asserted mid-command SHALL abort the command with no done pulse.
- REQ-032 rst SHALL take priority over start.

Configuration
- REQ-033 With macro BUFFER_READER_STALL_CNT_EN defined, the module SHALL add output stall_cycles[15:0].
- REQ-034 stall_cycles SHALL count cycles with out_valid && !out_ready, saturate at 16'hFFFF, clear on an accepted start, and clear on rst.
- REQ-035 Without the macro, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
- REQ-036 Package eyeriss_buf_pkg SHALL hold the FSM state enum (IDLE, READ, DRAIN) and default DATA_WIDTH/DEPTH/LEN_WIDTH constants.
- REQ-037 Sub-module buffer_addr_gen SHALL hold the address register, stride adder and issued counter.
- REQ-038 buffer_addr_gen SHALL take load, advance and done-compare controls from the FSM.

Verification
- REQ-039 Scenario: base=2, stride=1, length=4, out_ready=1, Buffer preloaded mem[i]=i+100 -> out_data 102,103,104,105 on consecutive cycles, first valid after edge 2, done one cycle after the last beat.
- REQ-040 Scenario: DEPTH=16, base=14, stride=3, length=3 -> addresses 14,1,4 -> data mem[14],mem[1],mem[4].
- REQ-041 Scenario: length=4 with out_ready low for 3 cycles at beat 2 -> beat 2 held stable, no beat lost or duplicated, with the macro enabled stall_cycles=3.
- REQ-042 Scenario: length=0 -> done pulses once, out_valid never high, busy never high.
- REQ-043 Scenario: start pulsed again mid-command -> ignored, original sequence unchanged.
- REQ-044 Scenario: rst asserted after beat 1 of 5 -> next cycle all outputs 0, no done, and a new command runs correctly afterward.
